// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter (wr strobe / 8-bit data / busy) between N
// byte-stream requesters (console, debug trace, boot monitor, ...). Each
// byte is arbitrated round-robin. The arbiter then walks the transmitter
// handshake: strobe, wait for busy to rise, wait for busy to fall.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When defined, a requester that sends a byte with req_last=0 keeps the
//   transmitter locked until it sends a byte with req_last=1, or until it
//   has left the arbiter idle for LOCK_TIMEOUT cycles. This stops messages
//   from being interleaved. When undefined, req_last is ignored.
//
// Parameters:
//   N            number of requesters (2..8)
//   LOCK_TIMEOUT idle cycles before a held lock is dropped (lock build only)
//   IDW          grant index width, derived from N (do not override)
//
// Ports:
//   clk        system clock, all logic on posedge
//   resetq     synchronous reset, active low
//   req_valid  per-requester byte available
//   req_data   per-requester byte, requester i on [8i+7:8i]
//   req_last   byte is the last of a message (lock build only)
//   req_ready  one-hot accept pulse; the byte is consumed that cycle
//   tx_wr      registered 1-cycle write strobe to the transmitter
//   tx_data    registered byte to the transmitter, valid with tx_wr
//   tx_busy    transmitter busy; expected to rise the cycle after tx_wr
//   grant_id   index of the most recently granted requester
//   active     arbiter is not idle
//   err        1-cycle pulse: the transmitter never went busy
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int IDW          = $clog2(N)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             tx_wr,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             active,
  output logic             err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_IDLE = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;        // last granted index; search starts at ptr+1
  logic           wb_second;  // currently in the 2nd WAIT_BUSY cycle

  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] gnt;
  logic [7:0]     gnt_data;
  logic           grant;

`ifdef UART_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic           lock;
  logic [IDW-1:0] lock_id;
  logic [CW-1:0]  idle_cnt;

  // While locked, only the lock holder may be granted.
  assign elig = lock ? (req_valid & (N'(1) << lock_id)) : req_valid;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      lock     <= 1'b0;
      lock_id  <= '0;
      idle_cnt <= '0;
    end else if (grant) begin
      idle_cnt <= '0;
      lock     <= !req_last[gnt];
      lock_id  <= gnt;
    end else if (state == S_IDLE && lock && !req_valid[lock_id]) begin
      // Holder has gone quiet; release the transmitter after the timeout.
      if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
        lock     <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
  logic unused_last;

  assign elig        = req_valid;
  assign unused_last = ^req_last;
`endif

  // Round-robin search: first eligible index from ptr+1 upward, wrapping.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found    = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    for (int k = 1; k <= N; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr) + k) % N);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gnt == IDW'(i)) gnt_data = req_data[i*8 +: 8];
    end
  end

  // A grant is only taken in IDLE with the transmitter free. Gating with
  // resetq keeps req_ready from claiming a byte the reset will discard.
  assign grant  = resetq && (state == S_IDLE) && !tx_busy && found;
  assign active = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state     <= S_IDLE;
      ptr       <= IDW'(N - 1);  // requester 0 wins the first arbitration
      wb_second <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      err       <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            tx_data  <= gnt_data;
            tx_wr    <= 1'b1;
            grant_id <= gnt;
            ptr      <= gnt;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wb_second <= 1'b0;
          state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_IDLE;
          end else if (wb_second) begin
            // Transmitter ignored the strobe; flag it and drop the byte.
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wb_second <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
